alexsegura_pong: RTL and testbench

VGA Pong game for a TinyTapeout tile: two player paddles, one bouncing ball and two score counters. Produces 640x480@60 Hz video on the TinyVGA PMOD pinout and reads paddle buttons from the dedicated inputs. Both scores are driven on the bidirectional pins for observation. The block is the top level of the tile.

---
 rtl/pong_pkg.sv | 52 +++++
 rtl/vga_timing.sv | 38 +++
 rtl/alexsegura_pong.sv | 131 +++++++++++++
 tb/tb_alexsegura_pong.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared geometry and timing constants for the Pong tile, plus the small
// arithmetic helpers used by the game logic and the pixel generator.
package pong_pkg;

  typedef logic signed [10:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
    coord_t dx;
    coord_t dy;
  } ball_t;

  localparam logic [9:0] H_VISIBLE    = 10'd640;
  localparam logic [9:0] H_SYNC_START = 10'd656;
  localparam logic [9:0] H_SYNC_END   = 10'd752;
  localparam logic [9:0] H_TOTAL      = 10'd800;
  localparam logic [9:0] V_VISIBLE    = 10'd480;
  localparam logic [9:0] V_SYNC_START = 10'd490;
  localparam logic [9:0] V_SYNC_END   = 10'd492;
  localparam logic [9:0] V_TOTAL      = 10'd525;

  localparam coord_t PAD_W      = 11'sd8;
  localparam coord_t PAD_H      = 11'sd64;
  localparam coord_t BALL_SIZE  = 11'sd8;
  localparam coord_t P1_X       = 11'sd16;
  localparam coord_t P2_X       = 11'sd616;
  localparam coord_t PAD_Y_MAX  = 11'sd416;
  localparam coord_t PAD_Y0     = 11'sd208;
  localparam coord_t PAD_STEP   = 11'sd4;
  localparam coord_t BALL_X0    = 11'sd316;
  localparam coord_t BALL_Y0    = 11'sd236;
  localparam coord_t BALL_SPEED = 11'sd2;
  localparam coord_t BALL_X_MAX = 11'sd632;
  localparam coord_t BALL_Y_MAX = 11'sd472;

  function automatic coord_t paddle_step(coord_t y, logic up, logic dn);
    coord_t n;
    n = y;
    if (up && !dn)
      n = (y < PAD_STEP) ? 11'sd0 : y - PAD_STEP;
    else if (dn && !up)
      n = (y > PAD_Y_MAX - PAD_STEP) ? PAD_Y_MAX : y + PAD_STEP;
    return n;
  endfunction

  function automatic logic in_rect(coord_t a_x, coord_t a_y, coord_t r_x, coord_t r_y,
                                   coord_t r_w, coord_t r_h);
    return (a_x >= r_x) && (a_x < r_x + r_w) && (a_y >= r_y) && (a_y < r_y + r_h);
  endfunction

endpackage

// File: rtl/vga_timing.sv
// 640x480@60 Hz raster counters with raw negative-polarity syncs, visible
// flag and a once-per-frame game tick at the start of line 480.
module vga_timing
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       hsync,
  output logic       vsync,
  output logic       visible,
  output logic       tick
);

  logic [9:0] h_pos;
  logic [9:0] v_pos;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_pos <= '0;
      v_pos <= '0;
    end else if (h_pos == H_TOTAL - 10'd1) begin
      h_pos <= '0;
      v_pos <= (v_pos == V_TOTAL - 10'd1) ? '0 : v_pos + 10'd1;
    end else begin
      h_pos <= h_pos + 10'd1;
    end
  end

  assign h_cnt   = h_pos;
  assign v_cnt   = v_pos;
  assign hsync   = !((h_pos >= H_SYNC_START) && (h_pos < H_SYNC_END));
  assign vsync   = !((v_pos >= V_SYNC_START) && (v_pos < V_SYNC_END));
  assign visible = (h_pos < H_VISIBLE) && (v_pos < V_VISIBLE);
  assign tick    = (h_pos == 10'd0) && (v_pos == V_VISIBLE);

endmodule

// File: rtl/alexsegura_pong.sv
// Pong tile top: button synchronizer, paddle/ball/score state updated once
// per frame, and the registered TinyVGA pixel output.
module alexsegura_pong
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [9:0] h_cnt, v_cnt;
  logic       hsync, vsync, visible, tick;

  vga_timing u_timing (
    .clk     (clk),
    .rst_n   (rst_n),
    .h_cnt   (h_cnt),
    .v_cnt   (v_cnt),
    .hsync   (hsync),
    .vsync   (vsync),
    .visible (visible),
    .tick    (tick)
  );

  logic unused_in;
  assign unused_in = &{1'b0, ena, uio_in, ui_in[7:4]};

  logic [3:0] btn_meta, btn_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta <= '0;
      btn_sync <= '0;
    end else begin
      btn_meta <= ui_in[3:0];
      btn_sync <= btn_meta;
    end
  end

  ball_t      ball, ball_nxt;
  coord_t     p1_y, p2_y, p1_y_nxt, p2_y_nxt;
  logic [3:0] p1_score, p2_score, p1_score_nxt, p2_score_nxt;
  coord_t     nx, ny;
  logic       p1_hit, p2_hit, scored;

  assign nx     = ball.x + ball.dx;
  assign ny     = ball.y + ball.dy;
  assign p1_hit = (ball.y + BALL_SIZE > p1_y) && (ball.y < p1_y + PAD_H);
  assign p2_hit = (ball.y + BALL_SIZE > p2_y) && (ball.y < p2_y + PAD_H);

  // Paddle hits take priority over goals; a goal skips the vertical bounce.
  always_comb begin
    ball_nxt     = ball;
    p1_score_nxt = p1_score;
    p2_score_nxt = p2_score;
    scored       = 1'b0;
    if (ball.dx < 11'sd0 && nx <= P1_X + PAD_W && p1_hit) begin
      ball_nxt.x  = P1_X + PAD_W;
      ball_nxt.dx = BALL_SPEED;
    end else if (ball.dx < 11'sd0 && nx <= 11'sd0) begin
      p2_score_nxt = p2_score + 4'd1;
      ball_nxt.x   = BALL_X0;
      ball_nxt.y   = BALL_Y0;
      ball_nxt.dx  = -BALL_SPEED;
      scored       = 1'b1;
    end else if (ball.dx > 11'sd0 && nx >= P2_X - BALL_SIZE && p2_hit) begin
      ball_nxt.x  = P2_X - BALL_SIZE;
      ball_nxt.dx = -BALL_SPEED;
    end else if (ball.dx > 11'sd0 && nx >= BALL_X_MAX) begin
      p1_score_nxt = p1_score + 4'd1;
      ball_nxt.x   = BALL_X0;
      ball_nxt.y   = BALL_Y0;
      ball_nxt.dx  = BALL_SPEED;
      scored       = 1'b1;
    end else begin
      ball_nxt.x = nx;
    end
    if (!scored) begin
      if (ny <= 11'sd0) begin
        ball_nxt.y  = 11'sd0;
        ball_nxt.dy = BALL_SPEED;
      end else if (ny >= BALL_Y_MAX) begin
        ball_nxt.y  = BALL_Y_MAX;
        ball_nxt.dy = -BALL_SPEED;
      end else begin
        ball_nxt.y = ny;
      end
    end
    p1_y_nxt = paddle_step(p1_y, btn_sync[0], btn_sync[1]);
    p2_y_nxt = paddle_step(p2_y, btn_sync[2], btn_sync[3]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ball     <= '{x: BALL_X0, y: BALL_Y0, dx: BALL_SPEED, dy: BALL_SPEED};
      p1_y     <= PAD_Y0;
      p2_y     <= PAD_Y0;
      p1_score <= '0;
      p2_score <= '0;
    end else if (tick) begin
      ball     <= ball_nxt;
      p1_y     <= p1_y_nxt;
      p2_y     <= p2_y_nxt;
      p1_score <= p1_score_nxt;
      p2_score <= p2_score_nxt;
    end
  end

  coord_t px, py;
  logic   white;

  assign px    = $signed({1'b0, h_cnt});
  assign py    = $signed({1'b0, v_cnt});
  assign white = visible && (in_rect(px, py, ball.x, ball.y, BALL_SIZE, BALL_SIZE) ||
                             in_rect(px, py, P1_X, p1_y, PAD_W, PAD_H) ||
                             in_rect(px, py, P2_X, p2_y, PAD_W, PAD_H));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) uo_out <= 8'h88;
    else        uo_out <= {hsync, {3{white}}, vsync, {3{white}}};
  end

  assign uio_out = {p2_score, p1_score};
  assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_alexsegura_pong.sv
// Self-checking bench for the Pong tile: a behavioural game/raster model is
// compared against uo_out/uio_out; the raster is jumped to points of interest.
module tb_alexsegura_pong;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;

  alexsegura_pong dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int m_bx, m_by, m_dx, m_dy, m_p1, m_p2, m_s1, m_s2;
  logic [9:0] jh, jv;

  task automatic model_reset();
    m_bx = 316; m_by = 236; m_dx = 2; m_dy = 2;
    m_p1 = 208; m_p2 = 208; m_s1 = 0; m_s2 = 0;
  endtask

  function automatic int move(input int y, input logic up, input logic dn);
    int n;
    n = y;
    if (up && !dn) n = n - 4;
    else if (dn && !up) n = n + 4;
    if (n < 0) n = 0;
    if (n > 416) n = 416;
    return n;
  endfunction

  task automatic model_tick(input logic [3:0] b);
    int nx, ny;
    bit scored;
    nx = m_bx + m_dx;
    ny = m_by + m_dy;
    scored = 0;
    if (m_dx < 0 && nx <= 24 && m_by + 8 > m_p1 && m_by < m_p1 + 64) begin
      m_bx = 24; m_dx = 2;
    end else if (m_dx < 0 && nx <= 0) begin
      m_s2 = (m_s2 + 1) % 16; m_bx = 316; m_by = 236; m_dx = -2; scored = 1;
    end else if (m_dx > 0 && nx >= 608 && m_by + 8 > m_p2 && m_by < m_p2 + 64) begin
      m_bx = 608; m_dx = -2;
    end else if (m_dx > 0 && nx >= 632) begin
      m_s1 = (m_s1 + 1) % 16; m_bx = 316; m_by = 236; m_dx = 2; scored = 1;
    end else begin
      m_bx = nx;
    end
    if (!scored) begin
      if (ny <= 0) begin m_by = 0; m_dy = 2; end
      else if (ny >= 472) begin m_by = 472; m_dy = -2; end
      else m_by = ny;
    end
    m_p1 = move(m_p1, b[0], b[1]);
    m_p2 = move(m_p2, b[2], b[3]);
  endtask

  function automatic logic [7:0] exp_uo(input int h, input int v);
    logic hs, vs, w;
    hs = !(h >= 656 && h < 752);
    vs = !(v >= 490 && v < 492);
    w  = (h < 640 && v < 480) &&
         ((h >= m_bx && h < m_bx + 8 && v >= m_by && v < m_by + 8) ||
          (h >= 16 && h < 24 && v >= m_p1 && v < m_p1 + 64) ||
          (h >= 616 && h < 624 && v >= m_p2 && v < m_p2 + 64));
    return {hs, w, w, w, vs, w, w, w};
  endfunction

  // Place the raster so that the next rising edge processes (hh, vv).
  task automatic jump(input int hh, input int vv);
    @(negedge clk);
    jh = 10'(hh);
    jv = 10'(vv);
    force dut.u_timing.h_pos = jh;
    force dut.u_timing.v_pos = jv;
    #1;
    release dut.u_timing.h_pos;
    release dut.u_timing.v_pos;
  endtask

  task automatic sample(input int hh, input int vv, output logic [7:0] val);
    jump(hh, vv);
    @(posedge clk);
    #1;
    val = uo_out;
  endtask

  task automatic do_tick(input logic [3:0] b);
    ui_in  = {4'($urandom_range(0, 15)), b};
    uio_in = 8'($urandom_range(0, 255));
    jump(600, 500);
    repeat (3) @(posedge clk);
    jump(0, 480);
    @(posedge clk);
    #1;
    model_tick(b);
  endtask

  task automatic scan(input bit do_jump, input int hh, input int vv, input int n,
                      output int bad, output int hs_low, output int vs_low, output string first);
    int h, v;
    logic [7:0] e;
    bad = 0; hs_low = 0; vs_low = 0; first = "none";
    if (do_jump) jump(hh, vv);
    h = hh; v = vv;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      e = exp_uo(h, v);
      if (uo_out !== e) begin
        if (bad == 0) first = $sformatf("h=%0d v=%0d got %02h want %02h", h, v, uo_out, e);
        bad++;
      end
      if (!uo_out[7]) hs_low++;
      if (!uo_out[3]) vs_low++;
      h++;
      if (h == 800) begin h = 0; v = (v == 524) ? 0 : v + 1; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (uo_out !== 8'h88) begin errors++; $display("FAIL reset_uo_out: got %02h, required 88", uo_out); end
    checks++; if (uio_out !== 8'h00) begin errors++; $display("FAIL reset_uio_out: got %02h, required 00", uio_out); end
    checks++; if (uio_oe !== 8'hFF) begin errors++; $display("FAIL reset_uio_oe: got %02h, required ff", uio_oe); end
  endtask

  task automatic test_hsync();
    int bad, hl, vl;
    string first;
    @(negedge clk);
    rst_n = 1'b1;
    scan(1'b0, 0, 0, 1600, bad, hl, vl, first);
    checks++; if (bad !== 0) begin errors++; $display("FAIL hsync_raster: %0d bad cycles (%s), required 0", bad, first); end
    checks++; if (hl !== 192) begin errors++; $display("FAIL hsync_low_count: got %0d, required 192", hl); end
  endtask

  task automatic test_frame();
    int bad, hl, vl;
    string first;
    logic [7:0] val;
    sample(318, 238, val);
    checks++; if (val !== 8'hFF) begin errors++; $display("FAIL ball_pixel: got %02h, required ff", val); end
    sample(100, 100, val);
    checks++; if (val !== 8'h88) begin errors++; $display("FAIL black_pixel: got %02h, required 88", val); end
    scan(1'b1, 0, 238, 800, bad, hl, vl, first);
    checks++; if (bad !== 0) begin errors++; $display("FAIL line238: %0d bad cycles (%s), required 0", bad, first); end
    scan(1'b1, 0, 488, 4000, bad, hl, vl, first);
    checks++; if (bad !== 0) begin errors++; $display("FAIL vsync_raster: %0d bad cycles (%s), required 0", bad, first); end
    checks++; if (vl !== 1600) begin errors++; $display("FAIL vsync_low_count: got %0d, required 1600", vl); end
  endtask

  task automatic test_both_buttons();
    logic [7:0] val;
    int ph[5] = '{20, 20, 20, 20, 620};
    int pv[5] = '{208, 207, 271, 272, 208};
    logic [7:0] pe[5] = '{8'hFF, 8'h88, 8'hFF, 8'h88, 8'hFF};
    for (int i = 0; i < 10; i++) do_tick(4'b0011);
    for (int i = 0; i < 5; i++) begin
      sample(ph[i], pv[i], val);
      checks++;
      if (val !== pe[i]) begin errors++; $display("FAIL both_pressed (%0d,%0d): got %02h, required %02h", ph[i], pv[i], val, pe[i]); end
    end
  endtask

  task automatic test_p1_up();
    logic [7:0] val;
    int pv[4] = '{10, 100, 0, 64};
    logic [7:0] pe[4] = '{8'hFF, 8'h88, 8'hFF, 8'h88};
    for (int i = 0; i < 60; i++) do_tick(4'b0001);
    for (int i = 0; i < 4; i++) begin
      sample(20, pv[i], val);
      checks++;
      if (val !== pe[i]) begin errors++; $display("FAIL p1_clamp (20,%0d): got %02h, required %02h", pv[i], val, pe[i]); end
    end
  endtask

  task automatic test_score();
    logic [7:0] val;
    int n = 0;
    int ph[4] = '{318, 316, 315, 324};
    int pv[4] = '{238, 236, 236, 240};
    logic [7:0] pe[4] = '{8'hFF, 8'hFF, 8'h88, 8'h88};
    while (uio_out[3:0] == 4'd0 && n < 200) begin
      do_tick(4'b0100);
      n++;
      checks++;
      if (uio_out !== {4'(m_s2), 4'(m_s1)}) begin errors++; $display("FAIL score_track tick %0d: got %02h, required %01h%01h", n, uio_out, m_s2, m_s1); end
    end
    checks++; if (uio_out !== 8'h01) begin errors++; $display("FAIL p1_goal: got %02h, required 01", uio_out); end
    for (int i = 0; i < 4; i++) begin
      sample(ph[i], pv[i], val);
      checks++;
      if (val !== pe[i]) begin errors++; $display("FAIL serve_pixel (%0d,%0d): got %02h, required %02h", ph[i], pv[i], val, pe[i]); end
    end
  endtask

  task automatic test_random();
    logic [7:0] val, e;
    logic [3:0] b;
    int ph[8], pv[8];
    for (int t = 0; t < 300; t++) begin
      b = 4'($urandom_range(0, 15));
      do_tick(b);
      checks++;
      if (uio_out !== {4'(m_s2), 4'(m_s1)}) begin errors++; $display("FAIL rand_score tick %0d: got %02h, required %01h%01h", t, uio_out, m_s2, m_s1); end
      ph = '{m_bx, m_bx + 8, m_bx + 3, 20, 20, 620, 620, $urandom_range(1, 799)};
      pv = '{m_by, m_by + 4, m_by + 8, m_p1, m_p1 + 64, m_p2, m_p2 + 63, $urandom_range(0, 479)};
      for (int i = 0; i < 8; i++) begin
        sample(ph[i], pv[i], val);
        e = exp_uo(ph[i], pv[i]);
        checks++;
        if (val !== e) begin errors++; $display("FAIL rand_pixel tick %0d (%0d,%0d): got %02h, required %02h", t, ph[i], pv[i], val, e); end
      end
    end
  endtask

  task automatic test_score_wrap();
    for (int t = 0; t < 2600; t++) begin
      do_tick(4'b0101);
      checks++;
      if (uio_out !== {4'(m_s2), 4'(m_s1)}) begin errors++; $display("FAIL wrap_score tick %0d: got %02h, required %01h%01h", t, uio_out, m_s2, m_s1); end
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] val, e;
    int bad, hl, vl;
    string first;
    sample(m_bx + 1, m_by + 1, val);
    e = exp_uo(m_bx + 1, m_by + 1);
    checks++; if (val !== e) begin errors++; $display("FAIL pre_reset_pixel: got %02h, required %02h", val, e); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (uo_out !== 8'h88) begin errors++; $display("FAIL async_reset_uo_out: got %02h, required 88", uo_out); end
    checks++; if (uio_out !== 8'h00) begin errors++; $display("FAIL async_reset_scores: got %02h, required 00", uio_out); end
    model_reset();
    ui_in = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    scan(1'b0, 0, 0, 800, bad, hl, vl, first);
    checks++; if (bad !== 0) begin errors++; $display("FAIL post_reset_line0: %0d bad cycles (%s), required 0", bad, first); end
    sample(318, 238, val);
    checks++; if (val !== 8'hFF) begin errors++; $display("FAIL post_reset_ball: got %02h, required ff", val); end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_hsync();
    test_frame();
    test_both_buttons();
    test_p1_up();
    test_score();
    test_random();
    test_score_wrap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
